muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width.
REQ-002 Parameter REG_AW, default 5, SHALL set the destination register address width.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 START  input  1  SHALL request an operation; sampled only while BUSY=0.
REQ-006 OP  input  2  SHALL select the operation: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
REQ-007 SRC_A  input  XLEN  SHALL carry operand A (register-file RD1); dividend for DIVU/REMU.
REQ-008 SRC_B  input  XLEN  SHALL carry operand B (register-file RD2); divisor for DIVU/REMU.
REQ-009 DEST  input  REG_AW  SHALL carry the destination register index.
REQ-010 BUSY  output  1  SHALL be high while an operation is in flight.
REQ-011 DONE  output  1  SHALL be a one-cycle completion pulse.
REQ-012 WE3  output  1  SHALL drive the register-file write enable.
REQ-013 A3  output  REG_AW  SHALL drive the register-file write address.
REQ-014 WD3  output  XLEN  SHALL drive the register-file write data.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, FIN.
REQ-016 In IDLE with START=1, the unit SHALL latch OP, SRC_A, SRC_B and DEST, clear a 6-bit iteration counter, and enter RUN; this is cycle 0.
REQ-017 Operands SHALL be used only from the latched copies; input changes after cycle 0 SHALL NOT affect the result.
REQ-018 RUN SHALL perform one iteration per cycle for exactly XLEN cycles (cycles 1..32), then enter FIN.
REQ-019 MUL/MULHU SHALL use unsigned shift-add over a 2*XLEN product; MUL returns bits [31:0], MULHU returns bits [63:32].
REQ-020 DIVU/REMU SHALL use restoring division, one quotient bit per cycle, MSB first; DIVU returns the quotient, REMU returns the remainder.
REQ-021 Divisor zero SHALL yield DIVU = 0xFFFFFFFF and REMU = dividend, with no special-case latency.
REQ-022 In FIN (cycle 33), DONE SHALL be 1, A3 SHALL equal the latched DEST, and WD3 SHALL hold the result; the next state SHALL be IDLE.
REQ-023 WE3 SHALL equal DONE AND (latched DEST != 0); a write to register 0 SHALL be suppressed, but DONE still pulses.
REQ-024 BUSY SHALL be 1 in cycles 1..33 and 0 in IDLE; fixed latency SHALL be 33 cycles from accept to write.
REQ-025 START while BUSY=1, including the FIN cycle, SHALL be ignored and not queued.
REQ-026 Back-to-back operation: START sampled in the first IDLE cycle after FIN SHALL be accepted, giving a 34-cycle minimum issue interval.
REQ-027 WE3, DONE and A3 SHALL be registered, glitch-free outputs; WD3 SHALL be 0 whenever DONE=0.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE and set BUSY=0, DONE=0, WE3=0, A3=0, WD3=0, the counter to 0 and the internal accumulators to 0.
REQ-029 RST during RUN or FIN SHALL abandon the operation; no WE3 pulse SHALL follow.
REQ-030 START coincident with RST SHALL be ignored.

Structure
REQ-031 Shared package muldiv_pkg SHALL hold the OP encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU), the FSM state encoding, and XLEN/REG_AW defaults.
REQ-032 The combinational per-iteration step (shift-add or compare-subtract) SHALL be one sub-module, mdu_step; the FSM and registers SHALL stay in muldiv_unit.

Verification
REQ-033 MUL 7 x 6, DEST=5 -> at cycle 33: WE3=1, A3=5, WD3=42; BUSY=0 at cycle 34.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF, DEST=3 -> WD3=0xFFFFFFFE; MUL with the same operands -> WD3=0x00000001.
REQ-035 DIVU 100 / 7 -> WD3=14; REMU 100 / 7 -> WD3=2; DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234.
REQ-036 START with MUL 2 x 3 pulsed at cycle 5 of a busy operation -> ignored; exactly one WE3, at cycle 33, carrying the first result.
REQ-037 RST at cycle 10 of DIVU -> BUSY=0 on the next cycle, no WE3 for 40 cycles; MUL 1 x 1 with DEST=0 -> DONE=1 at cycle 33, WE3=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default widths,
// operation and FSM state encodings, and small decode helpers.
package muldiv_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // Divide-family operations use the compare-subtract step
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    // MULHU and REMU return the upper half of the accumulator
    function automatic logic op_wants_high(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One combinational iteration of the shared accumulator datapath:
// unsigned shift-add for multiply, restoring compare-subtract for divide.
// Accumulator layout is {upper X+1 bits, lower X bits}; for multiply the
// lower half holds the remaining multiplier, for divide it holds the
// remaining dividend bits and collects quotient bits at the LSB.
module mdu_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              is_div_i,
    input  logic [2*XLEN:0]   acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN:0]   acc_o
);

    logic [XLEN:0]   mul_sum;
    logic [2*XLEN:0] mul_acc;
    logic [2*XLEN:0] div_shift;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN:0] div_acc;

    // Compute both step variants and select by operation family
    always_comb begin
        mul_sum   = acc_i[2*XLEN:XLEN] + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
        mul_acc   = {mul_sum, acc_i[XLEN-1:0]} >> 1;

        div_shift = acc_i << 1;
        div_diff  = {1'b0, div_shift[2*XLEN:XLEN]} - {2'b00, opnd_i};
        div_acc   = div_shift;
        // No borrow means the divisor fits: keep the difference, set quotient bit
        if (!div_diff[XLEN+1]) begin
            div_acc[2*XLEN:XLEN] = div_diff[XLEN:0];
            div_acc[0]           = 1'b1;
        end

        acc_o = is_div_i ? div_acc : mul_acc;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with a fixed 33-cycle latency
// from accept to register-file write. Operands are latched at accept; the
// result is written through WE3/A3/WD3 during the single FIN cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        OP,
    input  logic [XLEN-1:0]   SRC_A,
    input  logic [XLEN-1:0]   SRC_B,
    input  logic [REG_AW-1:0] DEST,
    output logic              BUSY,
    output logic              DONE,
    output logic              WE3,
    output logic [REG_AW-1:0] A3,
    output logic [XLEN-1:0]   WD3
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [REG_AW-1:0]   dest_q, dest_d;
    logic [2*XLEN:0]     acc_q, acc_d;
    logic [2*XLEN:0]     step_acc;

    logic                done_q, done_d;
    logic                we3_q, we3_d;
    logic [REG_AW-1:0]   a3_q, a3_d;
    logic [XLEN-1:0]     wd3_q, wd3_d;

    logic                last_iter;
    logic [XLEN-1:0]     result;

    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    // Result is taken from the final step output so it can be registered
    // on the same edge that enters FIN
    assign result = op_wants_high(op_q) ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];

    // State, datapath and output registers; reset clears everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            opnd_q  <= '0;
            dest_q  <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            we3_q   <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
        end
    end

    // Next-state: accept only from IDLE, run XLEN iterations, one FIN cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate while running
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        opnd_d = opnd_q;
        dest_d = dest_q;
        acc_d  = acc_q;
        if (state_q == ST_IDLE && START) begin
            op_d   = op_e'(OP);
            opnd_d = SRC_B;
            dest_d = DEST;
            cnt_d  = '0;
            acc_d  = {{(XLEN+1){1'b0}}, SRC_A};
        end else if (state_q == ST_RUN) begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs for the FIN cycle, registered so they are glitch-free
    always_comb begin
        done_d = (state_q == ST_RUN) && last_iter;
        a3_d   = done_d ? dest_q : '0;
        wd3_d  = done_d ? result : '0;
        we3_d  = done_d && (dest_q != '0);
    end

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = done_q;
    assign WE3  = we3_q;
    assign A3   = a3_q;
    assign WD3  = wd3_q;

endmodule
